// File: rtl/mul.sv
// rtl/mul.sv - sequential unsigned shift-add multiplier, one multiplier bit per clock
module mul #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   P,
    output logic                 complete
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic               start_q;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      count;

    logic               start_edge;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] acc_next;

    assign start_edge = start & ~start_q;

    // Add into the upper half keeping the carry, then shift the whole accumulator right.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_next = {sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            count    <= '0;
            P        <= '0;
            complete <= 1'b0;
        end else begin
            start_q <= start;
            case (state)
                IDLE, DONE: begin
                    if (start_edge) begin
                        mcand    <= A;
                        mplier   <= B;
                        acc      <= '0;
                        count    <= '0;
                        complete <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST) begin
                        P        <= acc_next;
                        complete <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
